// File: rtl/memory_manager.sv
// memory_manager: arbitrates one 128K x 8 async SRAM between video scan-out and MCU accesses.
// Defining MEMORY_MANAGER_READBACK_EN adds the MCU read path (RD_SETUP/RD_LATCH).
module memory_manager #(
  parameter int unsigned RAM_WAIT_STATES = 0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic [2:0]  o_current_state,
  input  logic [8:0]  i_video_x_coord,
  input  logic [7:0]  i_video_y_coord,
  output logic [7:0]  o_video_data,
  output logic        o_video_data_ready,
  input  logic [8:0]  i_memory_x_coord,
  input  logic [7:0]  i_memory_y_coord,
  input  logic        i_memory_read_request,
  input  logic        i_memory_write_request,
  input  logic [7:0]  i_memory_write_data,
  output logic [7:0]  o_memory_read_data,
  output logic        o_memory_read_complete,
  output logic        o_memory_write_complete,
  output logic [16:0] o_ram_address,
  inout  wire  [7:0]  io_ram_data,
  output logic        o_ram_output_enable,
  output logic        o_ram_write_enable
);

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = (RAM_WAIT_STATES > 0) ? $clog2(RAM_WAIT_STATES + 1) : 1;
  localparam logic [ADDR_W-1:0] NO_VIDEO_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VID_SETUP = 3'd1,
    S_VID_LATCH = 3'd2,
    S_WR_SETUP  = 3'd3,
    S_WR_STROBE = 3'd4,
    S_WR_DONE   = 3'd5,
    S_RD_SETUP  = 3'd6,
    S_RD_LATCH  = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] r_last_video_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_video_data;
  logic              r_video_ready;
  logic              r_wr_complete;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_drive;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic [ADDR_W-1:0] w_video_addr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_video_pend;
  logic              w_rd_req;
  logic              w_strobe_state;
  logic              w_strobe_last;
  logic              w_load_addr;
  logic              w_video_done;
  logic              w_oe_n;
  logic              w_we_n;
  logic              w_drive;

  assign w_video_addr   = {i_video_y_coord, i_video_x_coord};
  assign w_mem_addr     = {i_memory_y_coord, i_memory_x_coord};
  assign w_video_pend   = (w_video_addr != r_last_video_addr);
  assign w_strobe_state = (r_state inside {S_VID_LATCH, S_WR_STROBE, S_RD_LATCH});
  assign w_strobe_last  = (r_wait_cnt == WAIT_W'(RAM_WAIT_STATES));
  assign w_video_done   = (r_state == S_VID_LATCH) && w_strobe_last;

  // Next-state arbitration: video > MCU write > MCU read
  always_comb begin
    w_next_state = r_state;
    w_load_addr  = 1'b0;
    w_sel_addr   = w_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (w_video_pend) begin
          w_next_state = S_VID_SETUP;
          w_load_addr  = 1'b1;
          w_sel_addr   = w_video_addr;
        end else if (i_memory_write_request) begin
          w_next_state = S_WR_SETUP;
          w_load_addr  = 1'b1;
        end else if (w_rd_req) begin
          w_next_state = S_RD_SETUP;
          w_load_addr  = 1'b1;
        end
      end
      S_VID_SETUP: w_next_state = S_VID_LATCH;
      S_VID_LATCH: if (w_strobe_last) w_next_state = S_IDLE;
      S_WR_SETUP:  w_next_state = S_WR_STROBE;
      S_WR_STROBE: if (w_strobe_last) w_next_state = S_WR_DONE;
      S_WR_DONE:   w_next_state = S_IDLE;
      S_RD_SETUP:  w_next_state = S_RD_LATCH;
      S_RD_LATCH:  if (w_strobe_last) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the pins are registered yet state-aligned
  assign w_oe_n  = !(w_next_state inside {S_VID_SETUP, S_VID_LATCH, S_RD_SETUP, S_RD_LATCH});
  assign w_we_n  = (w_next_state != S_WR_STROBE);
  assign w_drive = (w_next_state inside {S_WR_SETUP, S_WR_STROBE, S_WR_DONE});

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_ram_addr        <= '0;
      r_last_video_addr <= NO_VIDEO_ADDR;
      r_video_data      <= '0;
      r_video_ready     <= 1'b0;
      r_wr_complete     <= 1'b0;
      r_oe_n            <= 1'b1;
      r_we_n            <= 1'b1;
      r_drive           <= 1'b0;
      r_wait_cnt        <= '0;
    end else begin
      r_state       <= w_next_state;
      r_oe_n        <= w_oe_n;
      r_we_n        <= w_we_n;
      r_drive       <= w_drive;
      r_video_ready <= w_video_done;
      r_wr_complete <= (r_state == S_WR_STROBE) && w_strobe_last;
      if (w_load_addr) r_ram_addr <= w_sel_addr;
      if (w_strobe_state && !w_strobe_last) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      else                                  r_wait_cnt <= '0;
      if (w_video_done) begin
        r_video_data      <= io_ram_data;
        r_last_video_addr <= r_ram_addr;
      end
    end
  end

  // Write byte is pure datapath; its bus driver is gated by r_drive, which is reset
  always_ff @(posedge i_clock) begin
    if (w_load_addr) r_wr_data <= i_memory_write_data;
  end

`ifdef MEMORY_MANAGER_READBACK_EN
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_complete;
  logic              w_rd_done;

  assign w_rd_req  = i_memory_read_request;
  assign w_rd_done = (r_state == S_RD_LATCH) && w_strobe_last;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rd_data     <= '0;
      r_rd_complete <= 1'b0;
    end else begin
      r_rd_complete <= w_rd_done;
      if (w_rd_done) r_rd_data <= io_ram_data;
    end
  end

  assign o_memory_read_data     = r_rd_data;
  assign o_memory_read_complete = r_rd_complete;
`else
  logic w_unused_rd_req;

  assign w_rd_req               = 1'b0;
  assign w_unused_rd_req        = i_memory_read_request;
  assign o_memory_read_data     = '0;
  assign o_memory_read_complete = 1'b0;
`endif

  assign o_current_state         = r_state;
  assign o_video_data            = r_video_data;
  assign o_video_data_ready      = r_video_ready;
  assign o_memory_write_complete = r_wr_complete;
  assign o_ram_address           = r_ram_addr;
  assign o_ram_output_enable     = r_oe_n;
  assign o_ram_write_enable      = r_we_n;
  assign io_ram_data             = r_drive ? r_wr_data : 8'hzz;

endmodule

// File: tb/tb_memory_manager.sv
// tb_memory_manager: table-driven + scoreboard bench for memory_manager with a behavioural SRAM.
module tb_memory_manager;

  localparam int unsigned WS  = 0;
  localparam int          LAT = 3 + WS;
  localparam logic [1:0]  K_WR = 2'd0, K_VID = 2'd1, K_RD = 2'd2;

  typedef struct { logic [16:0] addr; logic [7:0] data; } exp_t;
  typedef struct {
    logic [1:0]  kind;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [16:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [8:0]  vx, mx;
  logic [7:0]  vy, my;
  logic [7:0]  vdata, wdata, rdata;
  logic        vready, rreq, wreq, rcmpl, wcmpl;
  logic [16:0] raddr;
  wire  [7:0]  ram_data;
  logic        oe_n, we_n;
  logic        probe;

  logic [7:0]  sram [0:131071];
  logic [16:0] last_wa;
  logic [7:0]  last_wd;
  int          n_sram_wr = 0;
  int          n_vready = 0, n_wcmpl = 0, n_rcmpl = 0;
  int          we_low = 0;
  int          n_tests = 0, n_fail = 0;

  exp_t vq[$], wq[$], rq[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  memory_manager #(.RAM_WAIT_STATES(WS)) dut (
    .i_clock                 (clk),
    .i_reset                 (rst),
    .o_current_state         (state),
    .i_video_x_coord         (vx),
    .i_video_y_coord         (vy),
    .o_video_data            (vdata),
    .o_video_data_ready      (vready),
    .i_memory_x_coord        (mx),
    .i_memory_y_coord        (my),
    .i_memory_read_request   (rreq),
    .i_memory_write_request  (wreq),
    .i_memory_write_data     (wdata),
    .o_memory_read_data      (rdata),
    .o_memory_read_complete  (rcmpl),
    .o_memory_write_complete (wcmpl),
    .o_ram_address           (raddr),
    .io_ram_data             (ram_data),
    .o_ram_output_enable     (oe_n),
    .o_ram_write_enable      (we_n)
  );

  // Async SRAM: drives the bus while OE is low, commits on the rising edge of WE
  assign ram_data = !oe_n ? sram[raddr] : (probe ? 8'h00 : 8'hzz);

  always @(posedge we_n) begin
    if (!rst) begin
      sram[raddr] <= ram_data;
      last_wa     <= raddr;
      last_wd     <= ram_data;
      n_sram_wr   <= n_sram_wr + 1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: pops an expectation whenever the DUT pulses a done strobe
  always @(negedge clk) begin
    exp_t e;
    if (rst) we_low = 0;
    else if (!we_n) we_low++;
    if (!oe_n && !we_n) chk("oe_we_both_low", 1, 0);
    if (wcmpl) begin
      n_wcmpl++;
      if (wq.size() == 0) chk("unexpected_write_complete", 1, 0);
      else begin
        e = wq.pop_front();
        chk("write_addr", 32'(last_wa), 32'(e.addr));
        chk("write_data", 32'(last_wd), 32'(e.data));
        chk("we_low_clocks", we_low, 1 + WS);
      end
      we_low = 0;
    end
    if (vready) begin
      n_vready++;
      if (vq.size() == 0) chk("unexpected_video_ready", 1, 0);
      else begin
        e = vq.pop_front();
        chk("video_addr", 32'(raddr), 32'(e.addr));
        chk("video_data", 32'(vdata), 32'(e.data));
      end
    end
    if (rcmpl) begin
      n_rcmpl++;
      if (rq.size() == 0) chk("unexpected_read_complete", 1, 0);
      else begin
        e = rq.pop_front();
        chk("read_addr", 32'(raddr), 32'(e.addr));
        chk("read_data", 32'(rdata), 32'(e.data));
      end
    end
  end

  task automatic do_write(input logic [8:0] x, input logic [7:0] y, input logic [7:0] d,
                          input logic [16:0] ea, output int lat);
    exp_t e;
    e.addr = ea; e.data = d; wq.push_back(e);
    mx = x; my = y; wdata = d; wreq = 1'b1; lat = 0;
    do begin @(negedge clk); lat++; end while (!wcmpl && lat < 50);
    wreq = 1'b0;
    @(negedge clk);
    chk("write_complete_one_clock", 32'(wcmpl), 0);
  endtask

  task automatic do_video(input logic [8:0] x, input logic [7:0] y, input logic [16:0] ea,
                          input logic [7:0] ed, output int lat);
    exp_t e;
    e.addr = ea; e.data = ed; vq.push_back(e);
    vx = x; vy = y; lat = 0;
    do begin @(negedge clk); lat++; end while (!vready && lat < 50);
    @(negedge clk);
    chk("video_ready_one_clock", 32'(vready), 0);
  endtask

`ifdef MEMORY_MANAGER_READBACK_EN
  task automatic do_read(input logic [8:0] x, input logic [7:0] y, input logic [16:0] ea,
                         input logic [7:0] ed, output int lat);
    exp_t e;
    e.addr = ea; e.data = ed; rq.push_back(e);
    mx = x; my = y; rreq = 1'b1; lat = 0;
    do begin @(negedge clk); lat++; end while (!rcmpl && lat < 50);
    rreq = 1'b0;
    @(negedge clk);
    chk("read_complete_one_clock", 32'(rcmpl), 0);
  endtask
`endif

  initial begin
    int lat, base, cnt, t_v, t_w, max_st;
    vecs[0] = '{K_WR,  9'd0,   8'd0,   17'h00000, 8'h11};
    vecs[1] = '{K_WR,  9'd511, 8'd255, 17'h1FFFF, 8'hFF};
    vecs[2] = '{K_VID, 9'd0,   8'd0,   17'h00000, 8'h11};
    vecs[3] = '{K_WR,  9'd5,   8'd3,   17'h00605, 8'h3C};
    vecs[4] = '{K_VID, 9'd5,   8'd3,   17'h00605, 8'h3C};
    vecs[5] = '{K_WR,  9'd100, 8'd128, 17'h10064, 8'h77};
    vecs[6] = '{K_VID, 9'd100, 8'd128, 17'h10064, 8'h77};
    vecs[7] = '{K_RD,  9'd5,   8'd3,   17'h00605, 8'h3C};
    vecs[8] = '{K_VID, 9'd511, 8'd255, 17'h1FFFF, 8'hFF};

    rst = 1'b1; probe = 1'b1;
    vx = 9'd511; vy = 8'd255; mx = '0; my = '0; wdata = '0; rreq = 1'b0; wreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(state), 0);
    chk("reset_oe_n", 32'(oe_n), 1);
    chk("reset_we_n", 32'(we_n), 1);
    chk("reset_ram_addr", 32'(raddr), 0);
    chk("reset_bus_released", 32'(ram_data), 0);
    chk("reset_pulses", 32'({vready, wcmpl, rcmpl}), 0);
    chk("reset_video_data", 32'(vdata), 0);
    chk("reset_read_data", 32'(rdata), 0);
    rst = 1'b0; probe = 1'b0;
    @(negedge clk);

    // Single MCU write at a row-end column, then verify it is not re-served
    base = n_sram_wr;
    do_write(9'd511, 8'd2, 8'h03, 17'h005FF, lat);
    chk("write_latency", lat, LAT);
    repeat (6) @(negedge clk);
    chk("single_sram_write", n_sram_wr, base + 1);
    chk("idle_after_write", 32'(state), 0);

    // Video fetch of a known byte, then no refetch while coordinates hold
    do_write(9'd10, 8'd1, 8'hA5, 17'h0020A, lat);
    do_video(9'd10, 8'd1, 17'h0020A, 8'hA5, lat);
    chk("video_latency", lat, LAT);
    base = n_vready;
    repeat (6) @(negedge clk);
    chk("no_refetch", n_vready, base);

    for (int i = 0; i < 9; i++) begin
      case (vecs[i].kind)
        K_WR: begin
          do_write(vecs[i].x, vecs[i].y, vecs[i].exp_data, vecs[i].exp_addr, lat);
          chk("vec_write_latency", lat, LAT);
        end
        K_VID: begin
          do_video(vecs[i].x, vecs[i].y, vecs[i].exp_addr, vecs[i].exp_data, lat);
          chk("vec_video_latency", lat, LAT);
        end
        default: begin
`ifdef MEMORY_MANAGER_READBACK_EN
          do_read(vecs[i].x, vecs[i].y, vecs[i].exp_addr, vecs[i].exp_data, lat);
          chk("vec_read_latency", lat, LAT);
`endif
        end
      endcase
    end

    // Video coordinate change and write request in the same clock: video wins
    do_write(9'd20, 8'd4, 8'h42, 17'h00814, lat);
    begin
      exp_t e;
      e.addr = 17'h00814; e.data = 8'h42; vq.push_back(e);
      e.addr = 17'h00E07; e.data = 8'h99; wq.push_back(e);
    end
    vx = 9'd20; vy = 8'd4; mx = 9'd7; my = 8'd7; wdata = 8'h99; wreq = 1'b1;
    t_v = 0; t_w = 0; cnt = 0;
    while ((t_v == 0 || t_w == 0) && cnt < 40) begin
      @(negedge clk); cnt++;
      if (vready) t_v = cnt;
      if (wcmpl) begin t_w = cnt; wreq = 1'b0; end
    end
    wreq = 1'b0;
    chk("contend_video_latency", t_v, LAT);
    chk("contend_write_latency", t_w, 2 * LAT);

    // Coordinates move during a fetch: old address completes, new one follows
    do_write(9'd30, 8'd2, 8'h10, 17'h0041E, lat);
    do_write(9'd31, 8'd2, 8'h20, 17'h0041F, lat);
    begin
      exp_t e;
      e.addr = 17'h0041E; e.data = 8'h10; vq.push_back(e);
      e.addr = 17'h0041F; e.data = 8'h20; vq.push_back(e);
    end
    vx = 9'd30; vy = 8'd2;
    @(negedge clk);
    vx = 9'd31;
    base = n_vready; cnt = 1; t_v = 0;
    while (n_vready < base + 2 && cnt < 40) begin
      @(negedge clk); cnt++;
      if (vready) t_v = cnt;
    end
    chk("midfetch_two_fetches", n_vready - base, 2);
    chk("midfetch_second_latency", t_v, 2 * LAT);

`ifdef MEMORY_MANAGER_READBACK_EN
    do_read(9'd511, 8'd2, 17'h005FF, 8'h03, lat);
    chk("readback_latency", lat, LAT);
`else
    base = n_rcmpl; max_st = 0;
    mx = 9'd511; my = 8'd2; rreq = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (int'(state) > max_st) max_st = int'(state);
    end
    rreq = 1'b0;
    chk("read_ignored_no_complete", n_rcmpl, base);
    chk("read_ignored_data_zero", 32'(rdata), 0);
    chk("read_ignored_no_rd_states", 32'(max_st < 6), 1);
`endif

    do_video(9'd511, 8'd255, 17'h1FFFF, 8'hFF, lat);
    chk("corner_video_latency", lat, LAT);

    // Reset asserted while WE is low aborts the write without committing or completing
    do_write(9'd1, 8'd1, 8'h33, 17'h00201, lat);
    mx = 9'd1; my = 8'd1; wdata = 8'h81; wreq = 1'b1; cnt = 0;
    do begin @(negedge clk); cnt++; end while (state != 3'd4 && cnt < 20);
    chk("reached_wr_strobe", 32'(state), 4);
    chk("we_low_in_strobe", 32'(we_n), 0);
    base = n_wcmpl;
    rst = 1'b1;
    #1;
    chk("abort_we_n", 32'(we_n), 1);
    chk("abort_oe_n", 32'(oe_n), 1);
    chk("abort_state", 32'(state), 0);
    probe = 1'b1;
    #1;
    chk("abort_bus_released", 32'(ram_data), 0);
    wreq = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; probe = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_complete", n_wcmpl, base);
    chk("abort_not_committed", 32'(sram[17'h00201]), 32'h33);
    chk("abort_idle", 32'(state), 0);

    chk("video_queue_drained", vq.size(), 0);
    chk("write_queue_drained", wq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
